ofm_writer: RTL and testbench
=============================

Name: ofm_writer

Overview:
- Consumer end of the convolution output stream, in the clk2 domain. Samples each out_valid/data_output beat from the conv core.
- Requantizes the 48-bit accumulator to a signed OFM word and generates raster-order OFM addresses (channel, row, col).
- Absorbs memory back-pressure in a small buffer, because the conv core cannot be stalled. Reports completion and error status.

Parameters:
DATA_WIDTH, 48, width of incoming accumulator word
OFM_WIDTH, 16, width of written OFM word (signed)
OFM_SIZE, 64, output feature map side length
CO, 8, number of output channels
SHIFT, 8, requant right-shift amount (1..DATA_WIDTH-1)
BUF_DEPTH, 4, entries in the write buffer (power of 2)
ADDR_WIDTH, $clog2(CO*OFM_SIZE*OFM_SIZE), OFM memory address width

Ports:
clk2  in  1  stream/memory clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse, clk2-synchronous: begin a new layer
out_valid  in  1  input beat valid
data_in  in  DATA_WIDTH  accumulator value, signed two's complement
end_conv  in  1  one-cycle pulse: conv core finished
mem_ready  in  1  memory accepts write this cycle
mem_we  out  1  write request
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  OFM_WIDTH  write data
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at layer completion
overflow  out  1  sticky: a beat was dropped because the buffer was full
count_err  out  1  sticky: end_conv beat count != CO*OFM_SIZE*OFM_SIZE

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE; buffer empty; col/row/ch/beat counters 0.
- FSM states and transitions:
  - IDLE: on start -> RUN. Entering RUN clears counters, overflow, count_err and the buffer.
  - RUN: on end_conv -> DRAIN.
  - DRAIN: when buffer empty and requant stage empty -> DONE.
  - DONE: pulse done for one cycle -> IDLE.
- start outside IDLE is ignored. out_valid outside RUN is ignored. end_conv outside RUN is ignored.
- Requant (stage 1, registered):
  - r = (data_in + 2^(SHIFT-1)) >>> SHIFT, computed at DATA_WIDTH+1 bits.
  - Saturate to [-2^(OFM_WIDTH-1), 2^(OFM_WIDTH-1)-1].
- Address generation:
  - On each accepted beat, addr = ch*OFM_SIZE^2 + row*OFM_SIZE + col, captured with the data.
  - col increments; at OFM_SIZE-1 it wraps to 0 and row increments.
  - row wraps at OFM_SIZE-1 and ch increments; ch wraps at CO-1 to 0.
  - Beat counter increments on every beat sampled in RUN, including dropped beats. Dropped beats still advance the address so that later data lands correctly.
- Latency:
  - Beat sampled at edge t; requant result pushed into the buffer at edge t+1.
  - mem_we/mem_addr/mem_wdata show the buffer head after edge t+1. Minimum latency is 2 cycles.
- Handshake:
  - mem_we = buffer non-empty.
  - A write completes on a cycle with mem_we & mem_ready. The head is popped at that edge.
  - mem_addr/mem_wdata hold stable while mem_we=1 and mem_ready=0.
- Full buffer:
  - A push while full with no simultaneous pop drops the word and sets overflow.
  - Push and pop on the same edge while full is legal; no drop.
- Empty buffer: mem_we=0; mem_addr/mem_wdata hold their last values.
- count_err is set at the end_conv edge if beat count (including a beat sampled on that same edge) != CO*OFM_SIZE^2.
- Reset mid-operation: immediate return to reset state. Buffered data is discarded; no further writes.

Test Plan (OFM_SIZE=4, CO=2, SHIFT=4, BUF_DEPTH=4):
1. Requant, mem_ready=1:
   - data_in 24 -> wdata 0x0002
   - data_in -24 -> 0xFFFF
   - data_in 0x0000_0010_0000 -> 0x7FFF
   - data_in -0x0000_0010_0000 -> 0x8000
   - data_in 7 -> 0x0000
   - data_in 8 -> 0x0001
2. Full layer: start, 32 consecutive beats, mem_ready=1, end_conv after last beat.
   - Addresses 0..31 in order, each 2 cycles after its beat.
   - done pulses once; overflow=0, count_err=0; busy falls with done.
3. Back-pressure: mem_ready=0, 6 beats valued 16..96 step 16.
   - Buffer holds addr 0..3, data 1..4; beats 5-6 dropped; overflow=1.
   - Raise mem_ready: writes addr 0..3 only.
   - Next beat lands at addr 6.
4. Hold stability: mem_ready toggles 0/1 each cycle during 8 beats.
   - mem_addr/mem_wdata never change while mem_we=1 and mem_ready=0.
   - All 8 writes complete, no overflow.
5. Early end: 10 beats, then end_conv.
   - DRAIN completes the remaining writes, then done; count_err=1.
   - A following start clears count_err.
6. Reset mid-RUN with buffer full and mem_ready=0: assert rst_n low.
   - All outputs 0 immediately; FSM in IDLE.
   - No mem_we after release until a new start and beat.

Source files
------------

// File: rtl/ofm_writer.sv
// ofm_writer: consumer end of the convolution output stream (clk2 domain).
//   Samples accumulator beats, requantizes them to signed OFM words, tags each
//   word with its raster-order OFM address and writes it to memory through a
//   small buffer that absorbs back-pressure (the conv core cannot be stalled).
// Ports:
//   clk2, rst_n            clock, asynchronous active-low reset
//   start                  one-cycle pulse: begin a new layer (honoured in IDLE)
//   out_valid, data_in     accumulator beat from the conv core (honoured in RUN)
//   end_conv               one-cycle pulse: conv core finished (honoured in RUN)
//   mem_ready              memory accepts the presented write this cycle
//   mem_we/addr/wdata      write request, held stable until accepted
//   busy, done             layer in progress / one-cycle completion pulse
//   overflow, count_err    sticky status: dropped beat / wrong beat count
module ofm_writer #(
    parameter int DATA_WIDTH = 48,
    parameter int OFM_WIDTH  = 16,
    parameter int OFM_SIZE   = 64,
    parameter int CO         = 8,
    parameter int SHIFT      = 8,
    parameter int BUF_DEPTH  = 4,
    parameter int ADDR_WIDTH = $clog2(CO * OFM_SIZE * OFM_SIZE)
) (
    input  logic                  clk2,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  out_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  end_conv,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [OFM_WIDTH-1:0]  mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  count_err
);

    localparam int TOTAL  = CO * OFM_SIZE * OFM_SIZE;
    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(TOTAL + 1) + 1;
    localparam int ENT_W  = ADDR_WIDTH + OFM_WIDTH;

    localparam logic [DATA_WIDTH:0] RND_U = {{DATA_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [DATA_WIDTH:0] RND     = $signed(RND_U);
    localparam logic signed [DATA_WIDTH:0] SAT_MAX =
        (DATA_WIDTH + 1)'((64'sd1 <<< (OFM_WIDTH - 1)) - 64'sd1);
    // Two's complement: ~(2^(N-1)-1) == -2^(N-1)
    localparam logic signed [DATA_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Round-half-up arithmetic shift, one extra bit so the rounding add cannot wrap
    function automatic logic [OFM_WIDTH-1:0] requant(input logic [DATA_WIDTH-1:0] d);
        logic signed [DATA_WIDTH:0] sum;
        logic signed [DATA_WIDTH:0] shr;
        sum = $signed({d[DATA_WIDTH-1], d}) + RND;
        shr = sum >>> SHIFT;
        if (shr > SAT_MAX) begin
            requant = SAT_MAX[OFM_WIDTH-1:0];
        end else if (shr < SAT_MIN) begin
            requant = SAT_MIN[OFM_WIDTH-1:0];
        end else begin
            requant = shr[OFM_WIDTH-1:0];
        end
    endfunction

    state_t                 state_r, next_state_s;
    logic                   busy_s, done_s;
    logic                   run_entry_s, beat_s, end_s;
    logic                   s1_valid_r;
    logic [ADDR_WIDTH-1:0]  s1_addr_r;
    logic [OFM_WIDTH-1:0]   s1_data_r;
    // Raster order with col fastest makes ch*S^2+row*S+col a plain linear count
    logic [ADDR_WIDTH-1:0]  addr_cnt_r, addr_nxt_s;
    logic [BEAT_W-1:0]      beat_cnt_r, beat_total_s;
    logic                   overflow_r, count_err_r;
    logic [ENT_W-1:0]       buf_mem_r [BUF_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r, rd_inc_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic                   full_s, push_s, pop_s, drop_s;
    logic [ENT_W-1:0]       head_nxt_s;
    logic                   mem_we_r;
    logic [ADDR_WIDTH-1:0]  mem_addr_r;
    logic [OFM_WIDTH-1:0]   mem_wdata_r;

    assign run_entry_s = (state_r == ST_IDLE) && start;
    assign beat_s      = (state_r == ST_RUN) && out_valid;
    assign end_s       = (state_r == ST_RUN) && end_conv;
    assign full_s      = (cnt_r == CNT_W'(BUF_DEPTH));
    assign pop_s       = mem_we_r && mem_ready;
    assign push_s      = s1_valid_r && (!full_s || pop_s);
    assign drop_s      = s1_valid_r && full_s && !pop_s;
    assign rd_inc_s    = rd_ptr_r + PTR_W'(1);
    assign addr_nxt_s  = (addr_cnt_r == ADDR_WIDTH'(TOTAL - 1)) ? '0 : addr_cnt_r + ADDR_WIDTH'(1);
    // Includes a beat sampled on the same edge as end_conv
    assign beat_total_s = beat_cnt_r + BEAT_W'(beat_s);

    // FSM state register
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) next_state_s = ST_RUN; else next_state_s = ST_IDLE;
            ST_RUN:   if (end_conv) next_state_s = ST_DRAIN; else next_state_s = ST_RUN;
            ST_DRAIN: if ((cnt_r == '0) && !s1_valid_r) next_state_s = ST_DONE;
                      else next_state_s = ST_DRAIN;
            ST_DONE:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode (Moore, from the state register)
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_RUN:   busy_s = 1'b1;
            ST_DRAIN: busy_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            default:  begin busy_s = 1'b0; done_s = 1'b0; end
        endcase
    end

    // Stage 1: sample beats, requantize and tag with their raster address
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= '0;
            s1_data_r  <= '0;
            addr_cnt_r <= '0;
            beat_cnt_r <= '0;
        end else if (run_entry_s) begin
            s1_valid_r <= 1'b0;
            addr_cnt_r <= '0;
            beat_cnt_r <= '0;
        end else begin
            s1_valid_r <= beat_s;
            if (beat_s) begin
                s1_addr_r  <= addr_cnt_r;
                s1_data_r  <= requant(data_in);
                // Dropped beats still advance the address so later data lands correctly
                addr_cnt_r <= addr_nxt_s;
                if (beat_cnt_r != '1) beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
        end
    end

    // Sticky status flags, cleared when a new layer starts
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            count_err_r <= 1'b0;
        end else if (run_entry_s) begin
            overflow_r  <= 1'b0;
            count_err_r <= 1'b0;
        end else begin
            if (drop_s) overflow_r <= 1'b1;
            if (end_s && (beat_total_s != BEAT_W'(TOTAL))) count_err_r <= 1'b1;
        end
    end

    // Next buffer occupancy and the word that will be at the head after this edge
    always_comb begin
        cnt_nxt_s  = cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
        head_nxt_s = {mem_addr_r, mem_wdata_r};
        if (cnt_nxt_s != '0) begin
            // Buffer empty now (or about to be): the incoming word becomes the head
            if ((cnt_r == '0) || ((cnt_r == CNT_W'(1)) && pop_s)) begin
                head_nxt_s = {s1_addr_r, s1_data_r};
            end else if (pop_s) begin
                head_nxt_s = buf_mem_r[rd_inc_s];
            end else begin
                head_nxt_s = buf_mem_r[rd_ptr_r];
            end
        end else begin
            head_nxt_s = {mem_addr_r, mem_wdata_r};
        end
    end

    // Buffer storage (data only, no reset needed)
    always_ff @(posedge clk2) begin
        if (push_s && !run_entry_s) buf_mem_r[wr_ptr_r] <= {s1_addr_r, s1_data_r};
    end

    // Buffer pointers and registered write port; address/data hold when empty
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            cnt_r       <= '0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else if (run_entry_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            mem_we_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_inc_s;
            cnt_r    <= cnt_nxt_s;
            mem_we_r <= (cnt_nxt_s != '0);
            {mem_addr_r, mem_wdata_r} <= head_nxt_s;
        end
    end

    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_s;
    assign done      = done_s;
    assign overflow  = overflow_r;
    assign count_err = count_err_r;

endmodule

// File: tb/tb_ofm_writer.sv
// Testbench for ofm_writer (OFM_SIZE=4, CO=2, SHIFT=4, BUF_DEPTH=4).
// Expected writes are queued when beats are driven and compared when the
// memory accepts a write.
module tb_ofm_writer;
    localparam int OS = 4, NCO = 2, SH = 4, BD = 4, DW = 48, OW = 16, AW = 5;
    localparam int TOT = OS * OS * NCO;

    logic clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    logic          rst_n, start, out_valid, end_conv, mem_ready;
    logic [DW-1:0] data_in;
    logic          mem_we, busy, done, overflow, count_err;
    logic [AW-1:0] mem_addr;
    logic [OW-1:0] mem_wdata;

    ofm_writer #(.DATA_WIDTH(DW), .OFM_WIDTH(OW), .OFM_SIZE(OS), .CO(NCO),
                 .SHIFT(SH), .BUF_DEPTH(BD)) dut (
        .clk2(clk2), .rst_n(rst_n), .start(start), .out_valid(out_valid),
        .data_in(data_in), .end_conv(end_conv), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .overflow(overflow), .count_err(count_err));

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [OW-1:0] data;
        logic [31:0]   cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          nvec = 0, nerr = 0, exp_addr = 0, done_cnt = 0;
    logic [31:0] cyc = 32'd0;
    bit          lat_chk = 1'b0;
    logic        prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [OW-1:0] prev_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] rq_model(input longint d);
        longint r;
        r = (d + 64'sd8) >>> 4;
        if (r > 64'sd32767) return 16'h7fff;
        if (r < -64'sd32768) return 16'h8000;
        return r[OW-1:0];
    endfunction

    always @(posedge clk2) cyc <= cyc + 32'd1;

    // Write monitor: scoreboard compare, hold stability, done pulse count
    always @(negedge clk2) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("hold_addr", 64'(mem_addr), 64'(prev_addr));
                chk("hold_data", 64'(mem_wdata), 64'(prev_data));
            end
            if (mem_we && mem_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
                    chk("wr_data", 64'(mem_wdata), 64'(mon_e.data));
                    if (lat_chk) chk("latency", 64'(cyc - mon_e.cyc), 64'd2);
                end
            end
            prev_stall = mem_we && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk2);
        #1;
    endtask

    task automatic beat(input longint d, input bit keep, input logic [OW-1:0] ed);
        out_valid = 1'b1;
        data_in   = d[DW-1:0];
        if (keep) sb.push_back(exp_t'{addr: AW'(exp_addr), data: ed, cyc: cyc});
        exp_addr = (exp_addr + 1) % TOT;
        tick();
    endtask

    task automatic start_layer;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = 0;
        chk("busy_run", 64'(busy), 64'd1);
    endtask

    task automatic end_layer;
        out_valid = 1'b0;
        end_conv  = 1'b1;
        tick();
        end_conv  = 1'b0;
    endtask

    task automatic wait_done(input logic exp_cerr, input logic exp_ovf);
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        chk("count_err", 64'(count_err), 64'(exp_cerr));
        chk("sb_empty_at_done", 64'(sb.size()), 64'd0);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        longint d;
        rst_n = 1'b0; start = 1'b0; out_valid = 1'b0; end_conv = 1'b0;
        mem_ready = 1'b0; data_in = '0;
        #12;
        chk("reset_outs", 64'({mem_we, mem_addr, mem_wdata, busy, done, overflow, count_err}), 64'd0);
        @(negedge clk2);
        rst_n = 1'b1;
        tick(); tick();

        // Requant corner values, latency 2
        mem_ready = 1'b1;
        lat_chk   = 1'b1;
        start_layer();
        beat(64'sd24, 1'b1, 16'h0002);
        beat(-64'sd24, 1'b1, 16'hffff);
        beat(64'sh100000, 1'b1, 16'h7fff);
        beat(-64'sh100000, 1'b1, 16'h8000);
        beat(64'sd7, 1'b1, 16'h0000);
        beat(64'sd8, 1'b1, 16'h0001);
        end_layer();
        wait_done(1'b1, 1'b0);

        // Full layer of 32 beats
        start_layer();
        chk("cerr_cleared_1", 64'(count_err), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < TOT; i++) begin
            d = (longint'(i) - 64'sd16) * 64'sd601 + longint'(i);
            beat(d, 1'b1, rq_model(d));
        end
        end_layer();
        wait_done(1'b0, 1'b0);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        lat_chk = 1'b0;

        // Back-pressure: 4 buffered, beats 5 and 6 dropped
        mem_ready = 1'b0;
        start_layer();
        for (int k = 1; k <= 6; k++) beat(longint'(16 * k), (k <= 4), OW'(k));
        out_valid = 1'b0;
        tick(); tick();
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_we", 64'(mem_we), 64'd1);
        chk("bp_head_addr", 64'(mem_addr), 64'd0);
        chk("bp_head_data", 64'(mem_wdata), 64'd1);
        chk("bp_queued", 64'(sb.size()), 64'd4);
        mem_ready = 1'b1;
        repeat (6) tick();
        chk("bp_drained", 64'(sb.size()), 64'd0);
        chk("bp_we_idle", 64'(mem_we), 64'd0);
        beat(64'sd112, 1'b1, 16'h0007);
        out_valid = 1'b0;
        repeat (4) tick();
        chk("bp_next_written", 64'(sb.size()), 64'd0);
        end_layer();
        wait_done(1'b1, 1'b1);

        // Hold stability under toggling mem_ready
        start_layer();
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i % 2 == 0);
            d = longint'(i) * 64'sd4099 - 64'sd9000;
            beat(d, 1'b1, rq_model(d));
        end
        out_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (8) tick();
        chk("toggle_all_written", 64'(sb.size()), 64'd0);
        end_layer();
        wait_done(1'b1, 1'b0);

        // Early end: 10 beats
        start_layer();
        for (int i = 0; i < 10; i++) begin
            d = longint'(i) * 64'sd333;
            beat(d, 1'b1, rq_model(d));
        end
        end_layer();
        wait_done(1'b1, 1'b0);
        start_layer();
        chk("cerr_cleared_2", 64'(count_err), 64'd0);

        // Reset mid-RUN with full buffer and stalled memory
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) beat(longint'(i * 16), 1'b1, OW'(i));
        out_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", 64'({mem_we, mem_addr, mem_wdata, busy, done, overflow, count_err}), 64'd0);
        sb.delete();
        @(negedge clk2);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            out_valid = 1'b1;
            data_in = 48'd4096;
            tick();
            chk("no_we_after_rst", 64'(mem_we), 64'd0);
        end
        out_valid = 1'b0;
        start_layer();
        beat(64'sd48, 1'b1, 16'h0003);
        out_valid = 1'b0;
        repeat (3) tick();
        chk("post_rst_written", 64'(sb.size()), 64'd0);
        end_layer();
        wait_done(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
